// File: rtl/comparator_serial.sv
// Serial MSB-first magnitude comparator.
// Compares two WIDTH-bit operands DIGIT bits per clock, signed or unsigned,
// stopping at the first differing digit. Reports one-hot G/E/L plus the
// number of digits examined, behind a start/busy/done handshake.
//
// Handshake: start is sampled on a rising edge only while busy=0 (IDLE or
// DONE). An accepted start captures a, b and signed_mode and raises busy on
// that edge. done is a one-cycle pulse in the cycle after the deciding edge;
// G/E/L and digits_used are valid from done and hold until the next accepted
// start. start while busy=1 is ignored, nothing is queued.
module comparator_serial #(
  parameter  int WIDTH = 16,
  parameter  int DIGIT = 4,
  localparam int NDIG  = WIDTH / DIGIT,
  localparam int CW    = $clog2(NDIG + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             signed_mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             G,
  output logic             E,
  output logic             L,
  output logic [CW-1:0]    digits_used,
  output logic [1:0]       dbg_state
);

  // Reject parameter sets that do not split into whole digits.
  if ((DIGIT < 1) || (DIGIT > WIDTH) || ((WIDTH % DIGIT) != 0)) begin : g_param_check
    $fatal(1, "comparator_serial: WIDTH must be a multiple of DIGIT and DIGIT <= WIDTH");
  end

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CMP  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic [CW-1:0]    cnt;

  // Inverting both MSBs turns a two's-complement compare into an unsigned one,
  // so the digit datapath below never needs to know the mode.
  logic [WIDTH-1:0] msb_flip;
  logic [DIGIT-1:0] da;
  logic [DIGIT-1:0] db;
  logic             accept;
  logic             last;

  assign msb_flip  = WIDTH'(signed_mode) << (WIDTH - 1);
  assign da        = a_r[WIDTH-1 -: DIGIT];
  assign db        = b_r[WIDTH-1 -: DIGIT];
  assign accept    = start && (state != S_CMP);
  assign last      = (cnt == CW'(NDIG - 1));
  assign dbg_state = state;

  // Control FSM with registered outputs; operands shift left one digit per
  // cycle so the digit under test is always at the top of the registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      a_r         <= '0;
      b_r         <= '0;
      cnt         <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      G           <= 1'b0;
      E           <= 1'b0;
      L           <= 1'b0;
      digits_used <= '0;
    end else if (accept) begin
      state       <= S_CMP;
      a_r         <= a ^ msb_flip;
      b_r         <= b ^ msb_flip;
      cnt         <= '0;
      busy        <= 1'b1;
      done        <= 1'b0;
      G           <= 1'b0;
      E           <= 1'b0;
      L           <= 1'b0;
      digits_used <= '0;
    end else begin
      case (state)
        S_CMP: begin
          if (da > db) begin
            G           <= 1'b1;
            digits_used <= cnt + CW'(1);
            state       <= S_DONE;
            busy        <= 1'b0;
            done        <= 1'b1;
          end else if (da < db) begin
            L           <= 1'b1;
            digits_used <= cnt + CW'(1);
            state       <= S_DONE;
            busy        <= 1'b0;
            done        <= 1'b1;
          end else if (last) begin
            E           <= 1'b1;
            digits_used <= CW'(NDIG);
            state       <= S_DONE;
            busy        <= 1'b0;
            done        <= 1'b1;
          end else begin
            cnt <= cnt + CW'(1);
            a_r <= a_r << DIGIT;
            b_r <= b_r << DIGIT;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
          done  <= 1'b0;
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_comparator_serial.sv
// Testbench for comparator_serial (WIDTH=16, DIGIT=4).
// Directed cases for latency, signed/unsigned, busy-ignore, reset abort and
// back-to-back starts, then a random sweep against a behavioural compare.
module tb_comparator_serial;

  localparam int WIDTH = 16;
  localparam int DIGIT = 4;
  localparam int NDIG  = WIDTH / DIGIT;
  localparam int CW    = $clog2(NDIG + 1);
  localparam int EW    = CW + 3;

  logic             clk;
  logic             rst;
  logic             start;
  logic             signed_mode;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic             G;
  logic             E;
  logic             L;
  logic [CW-1:0]    digits_used;
  logic [1:0]       dbg_state;

  int total;
  int bad;

  // expected {G,E,L,digits_used} per accepted request
  logic [EW-1:0] exp_q[$];

  comparator_serial #(.WIDTH(WIDTH), .DIGIT(DIGIT)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .signed_mode (signed_mode),
    .a           (a),
    .b           (b),
    .busy        (busy),
    .done        (done),
    .G           (G),
    .E           (E),
    .L           (L),
    .digits_used (digits_used),
    .dbg_state   (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, bad=%0d", bad);
    $fatal(1, "watchdog");
  end

  // ---------------- checking helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference compare: result from plain signed/unsigned arithmetic, digit
  // count from the position of the first differing DIGIT-wide slice.
  function automatic logic [EW-1:0] model(input logic [WIDTH-1:0] x,
                                          input logic [WIDTH-1:0] y,
                                          input logic m);
    logic signed [WIDTH-1:0] sx;
    logic signed [WIDTH-1:0] sy;
    logic [WIDTH-1:0] diff;
    logic gt, lt, eq, found;
    int k;
    sx = x;
    sy = y;
    gt = m ? (sx > sy) : (x > y);
    lt = m ? (sx < sy) : (x < y);
    eq = (x == y);
    diff  = x ^ y;
    k     = NDIG;
    found = 1'b0;
    for (int d = 0; d < NDIG; d++) begin
      if (!found && (((diff >> (WIDTH - DIGIT * (d + 1))) & ((1 << DIGIT) - 1)) != 0)) begin
        k     = d + 1;
        found = 1'b1;
      end
    end
    return {gt, eq, lt, CW'(k)};
  endfunction

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    if (done) begin
      check("onehot_gel", 32'(G + E + L), 32'd1);
      check("busy_low_at_done", 32'(busy), 32'd0);
      if (exp_q.size() == 0) begin
        check("unexpected_done", 32'(done), 32'd0);
      end else begin
        logic [EW-1:0] e;
        e = exp_q.pop_front();
        check("result_gel_du", 32'({G, E, L, digits_used}), 32'(e));
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Drive a request for one cycle (call right after a negedge) and push the
  // expected response.
  task automatic issue(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y, input logic m);
    a           = x;
    b           = y;
    signed_mode = m;
    start       = 1'b1;
    exp_q.push_back(model(x, y, m));
  endtask

  // Called at the negedge after the start edge; waits for done and checks
  // that it arrives k+1 edges after start (k = digits needed).
  task automatic wait_done(input string name, input int exp_edges);
    int n;
    n = 1;
    while (!done && n < 20) begin
      @(negedge clk);
      n++;
    end
    check(name, 32'(n), 32'(exp_edges));
  endtask

  task automatic run(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y, input logic m, input string name);
    logic [EW-1:0] e;
    e = model(x, y, m);
    @(negedge clk);
    issue(x, y, m);
    @(negedge clk);
    start = 1'b0;
    a     = $urandom;
    b     = $urandom;
    wait_done(name, int'(e[CW-1:0]) + 1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [WIDTH-1:0] ra;
    logic [WIDTH-1:0] rb;
    logic             rm;
    total = 0;
    bad   = 0;
    rst = 1'b1;
    start = 1'b0;
    signed_mode = 1'b0;
    a = '0;
    b = '0;
    repeat (3) @(negedge clk);
    check("reset_outputs", 32'({busy, done, G, E, L, digits_used}), 32'd0);
    check("reset_state", 32'(dbg_state), 32'd0);
    rst = 1'b0;

    // 1: equal operands take all digits, done 5 edges after start
    run(16'h1234, 16'h1234, 1'b0, "lat_equal");
    check("equal_result", 32'({G, E, L, digits_used}), 32'({3'b010, CW'(4)}));

    // 2: first digit decides, unsigned vs signed
    run(16'h9000, 16'h1000, 1'b0, "lat_first_digit");
    check("unsigned_9000_gt", 32'({G, E, L, digits_used}), 32'({3'b100, CW'(1)}));
    run(16'h9000, 16'h1000, 1'b1, "lat_signed");
    check("signed_9000_lt", 32'({G, E, L, digits_used}), 32'({3'b001, CW'(1)}));

    // 3: last digit decides; signed -1 < 0
    run(16'h00F3, 16'h00F5, 1'b0, "lat_last_digit");
    check("last_digit_lt", 32'({G, E, L, digits_used}), 32'({3'b001, CW'(4)}));
    run(16'hFFFF, 16'h0000, 1'b1, "lat_signed_neg");
    check("signed_m1_lt_0", 32'({G, E, L, digits_used}), 32'({3'b001, CW'(1)}));

    // 4: start while busy is ignored
    @(negedge clk);
    issue(16'd5, 16'd3, 1'b0);
    @(negedge clk);
    check("busy_after_start", 32'(busy), 32'd1);
    a = 16'd3;
    b = 16'd6;
    @(negedge clk);
    start = 1'b0;
    wait_done("lat_busy_ignore", 5 - 1);
    check("busy_ignore_result", 32'({G, E, L}), 32'(3'b100));
    check("busy_clear_at_done", 32'(busy), 32'd0);
    repeat (2) @(negedge clk);

    // 5: reset mid-compare aborts with no done pulse
    @(negedge clk);
    a = 16'h1234;
    b = 16'h1235;
    signed_mode = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_outputs", 32'({busy, done, G, E, L, digits_used}), 32'd0);
    check("abort_state", 32'(dbg_state), 32'd0);
    repeat (8) @(negedge clk);

    // 6: back-to-back start accepted in the done cycle
    run(16'd7, 16'd7, 1'b0, "lat_b2b_first");
    issue(16'd3, 16'd6, 1'b0);
    @(negedge clk);
    start = 1'b0;
    check("b2b_cleared", 32'({G, E, L, busy}), 32'(4'b0001));
    wait_done("lat_b2b_second", 5);
    check("b2b_result", 32'({G, E, L, digits_used}), 32'({3'b001, CW'(4)}));

    // random sweep; half the vectors share leading digits with a
    for (int i = 0; i < 200; i++) begin
      ra = WIDTH'($urandom);
      rm = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 3))
        0: rb = WIDTH'($urandom);
        1: rb = ra;
        default: rb = ra ^ (WIDTH'($urandom_range(0, 15)) << (DIGIT * $urandom_range(0, NDIG - 1)));
      endcase
      run(ra, rb, rm, "lat_random");
      $display("%h | %h | %0d | %0d | %0d | %0d", ra, rb, rm, G, E, L);
    end

    repeat (4) @(negedge clk);
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
